fifo_drain_ctrl: RTL and testbench

FIFO_DRAIN_CTRL -- requirements
Module: fifo_drain_ctrl

---
 rtl/fifo_drain_ctrl.sv | 116 +++++++++++
 tb/tb_fifo_drain_ctrl.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_drain_ctrl.sv
// Drains an upstream FIFO into a 2-entry output buffer with a valid/ready output handshake.
// Optional define FIFO_DRAIN_BEAT_CNT_EN enables the 16-bit beat_cnt transfer counter.
`timescale 1ns/1ps
module fifo_drain_ctrl #(
    parameter int unsigned FIFO_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              drain_en,
    input  logic              fifo_empty,
    input  logic [FIFO_W-1:0] fifo_data,
    output logic              read_en,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FIFO_W-1:0] out_data,
    output logic [15:0]       beat_cnt
);

    typedef enum logic [1:0] {
        OccEmpty = 2'd0,
        OccOne   = 2'd1,
        OccTwo   = 2'd2
    } occ_e;

    occ_e              occ_q, occ_d;
    logic              inflight_q, inflight_d;
    logic              valid_q;
    logic [FIFO_W-1:0] head_q, head_d;
    logic [FIFO_W-1:0] tail_q, tail_d;
    logic              pop, push;
    logic [2:0]        credit;

    always_comb begin
        pop  = (occ_q != OccEmpty) && out_ready;
        push = inflight_q;
        // Occupancy seen at the edge: a departing word frees its slot for the word requested now,
        // which keeps one word per cycle flowing while still never exceeding two entries.
        credit  = {1'b0, occ_q} - {2'b00, pop} + {2'b00, inflight_q};
        read_en = !reset && drain_en && !fifo_empty && (credit < 3'd2);
    end

    always_comb begin
        occ_d      = occ_q;
        head_d     = head_q;
        tail_d     = tail_q;
        inflight_d = read_en;
        case ({push, pop})
            2'b10: begin
                if (occ_q == OccEmpty) begin
                    head_d = fifo_data;
                    occ_d  = OccOne;
                end else begin
                    tail_d = fifo_data;
                    occ_d  = OccTwo;
                end
            end
            2'b01: begin
                head_d = tail_q;
                occ_d  = (occ_q == OccTwo) ? OccOne : OccEmpty;
            end
            2'b11: begin
                if (occ_q == OccTwo) begin
                    head_d = tail_q;
                    tail_d = fifo_data;
                end else begin
                    head_d = fifo_data;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            occ_q      <= OccEmpty;
            inflight_q <= 1'b0;
            valid_q    <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            valid_q    <= (occ_d != OccEmpty);
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = head_q;

`ifdef FIFO_DRAIN_BEAT_CNT_EN
    logic [15:0] beat_cnt_q, beat_cnt_d;

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (pop) begin
            beat_cnt_d = beat_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_cnt_q <= 16'd0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end

    assign beat_cnt = beat_cnt_q;
`else
    assign beat_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Directed bench for fifo_drain_ctrl: a small FIFO model feeds the DUT, tasks check each scenario.
`timescale 1ns/1ps
module tb_fifo_drain_ctrl;

    localparam int FIFO_W = 32;
`ifdef FIFO_DRAIN_BEAT_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              drain_en = 1'b0;
    logic              fifo_empty;
    logic [FIFO_W-1:0] fifo_data = '0;
    logic              read_en;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [FIFO_W-1:0] out_data;
    logic [15:0]       beat_cnt;

    logic [FIFO_W-1:0] mem [0:63];
    int rd_ptr = 0;
    int wr_ptr = 0;
    int n_tests = 0;
    int n_fail = 0;

    fifo_drain_ctrl #(.FIFO_W(FIFO_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .drain_en  (drain_en),
        .fifo_empty(fifo_empty),
        .fifo_data (fifo_data),
        .read_en   (read_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .beat_cnt  (beat_cnt)
    );

    always #5 clk = ~clk;

    // Upstream FIFO model: data_out is valid the cycle after a read.
    assign fifo_empty = (rd_ptr == wr_ptr);
    always @(posedge clk) begin
        if (read_en) begin
            fifo_data <= mem[rd_ptr & 63];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    task automatic load(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            mem[wr_ptr & 63] = base + i;
            wr_ptr = wr_ptr + 1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        drain_en = 1'b0;
        out_ready = 1'b0;
        #1;
        wr_ptr = rd_ptr;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        #1;
        n_tests++;
        if (read_en !== 1'b0) begin
            $display("FAIL reset_read_en: got %b expected 0", read_en); n_fail++;
        end
        n_tests++;
        if (out_valid !== 1'b0) begin
            $display("FAIL reset_out_valid: got %b expected 0", out_valid); n_fail++;
        end
        n_tests++;
        if (out_data !== 32'h0) begin
            $display("FAIL reset_out_data: got %h expected 0", out_data); n_fail++;
        end
        n_tests++;
        if (beat_cnt !== 16'h0) begin
            $display("FAIL reset_beat_cnt: got %h expected 0", beat_cnt); n_fail++;
        end
        load(2, 1);
        drain_en = 1'b1;
        out_ready = 1'b1;
        #1;
        n_tests++;
        if (read_en !== 1'b0) begin
            $display("FAIL reset_hold_read_en: got %b expected 0", read_en); n_fail++;
        end
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (rd_ptr !== 0) begin
            $display("FAIL reset_no_reads: got %0d reads expected 0", rd_ptr); n_fail++;
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_tests++;
        if (read_en !== 1'b1) begin
            $display("FAIL release_read_en: got %b expected 1", read_en); n_fail++;
        end
    endtask

    task automatic test_streaming();
        logic        re [0:11];
        logic        ov [0:11];
        logic [31:0] od [0:11];
        do_reset();
        load(8, 1);
        @(negedge clk);
        drain_en = 1'b1;
        out_ready = 1'b1;
        #1;
        for (int c = 0; c < 12; c++) begin
            re[c] = read_en;
            ov[c] = out_valid;
            od[c] = out_data;
            @(negedge clk);
            #1;
        end
        for (int c = 0; c < 12; c++) begin
            n_tests++;
            if (re[c] !== (c < 8)) begin
                $display("FAIL stream_read_en[%0d]: got %b expected %b", c, re[c], (c < 8));
                n_fail++;
            end
            n_tests++;
            if (ov[c] !== (c >= 2 && c <= 9)) begin
                $display("FAIL stream_out_valid[%0d]: got %b expected %b", c, ov[c],
                         (c >= 2 && c <= 9));
                n_fail++;
            end
            if (c >= 2 && c <= 9) begin
                n_tests++;
                if (od[c] !== 32'(c - 1)) begin
                    $display("FAIL stream_out_data[%0d]: got %h expected %h", c, od[c], c - 1);
                    n_fail++;
                end
            end
        end
        n_tests++;
        if (beat_cnt !== (CNT_EN ? 16'd8 : 16'd0)) begin
            $display("FAIL stream_beat_cnt: got %0d expected %0d", beat_cnt, CNT_EN ? 8 : 0);
            n_fail++;
        end
    endtask

    task automatic test_backpressure();
        int reads = 0;
        int got = 0;
        do_reset();
        load(8, 1);
        @(negedge clk);
        drain_en = 1'b1;
        out_ready = 1'b0;
        #1;
        for (int c = 0; c < 10; c++) begin
            if (read_en) reads++;
            if (c >= 2) begin
                n_tests++;
                if (out_valid !== 1'b1 || out_data !== 32'h1 || read_en !== 1'b0) begin
                    $display("FAIL bp_hold[%0d]: got v=%b d=%h re=%b expected v=1 d=1 re=0",
                             c, out_valid, out_data, read_en);
                    n_fail++;
                end
            end
            @(negedge clk);
            #1;
        end
        n_tests++;
        if (reads !== 2) begin
            $display("FAIL bp_read_count: got %0d expected 2", reads); n_fail++;
        end
        out_ready = 1'b1;
        #1;
        for (int c = 0; c < 40 && got < 8; c++) begin
            if (out_valid) begin
                n_tests++;
                if (out_data !== 32'(got + 1)) begin
                    $display("FAIL bp_order[%0d]: got %h expected %h", got, out_data, got + 1);
                    n_fail++;
                end
                got++;
            end
            @(negedge clk);
            #1;
        end
        n_tests++;
        if (got !== 8) begin
            $display("FAIL bp_delivered: got %0d expected 8", got); n_fail++;
        end
    endtask

    task automatic test_empty();
        int bad = 0;
        do_reset();
        @(negedge clk);
        drain_en = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (read_en !== 1'b0 || out_valid !== 1'b0) bad++;
            @(negedge clk);
        end
        n_tests++;
        if (bad !== 0) begin
            $display("FAIL empty_idle: got %0d active cycles expected 0", bad); n_fail++;
        end
    endtask

    task automatic test_alternating();
        int got = 0;
        do_reset();
        load(4, 1);
        drain_en = 1'b1;
        for (int c = 0; c < 40 && got < 4; c++) begin
            @(negedge clk);
            out_ready = (c % 2 == 0);
            #1;
            if (out_valid && out_ready) begin
                n_tests++;
                if (out_data !== 32'(got + 1)) begin
                    $display("FAIL alt_order[%0d]: got %h expected %h", got, out_data, got + 1);
                    n_fail++;
                end
                got++;
            end
        end
        @(negedge clk);
        #1;
        n_tests++;
        if (got !== 4 || out_valid !== 1'b0) begin
            $display("FAIL alt_count: got %0d words valid=%b expected 4 words valid=0",
                     got, out_valid);
            n_fail++;
        end
        n_tests++;
        if (beat_cnt !== (CNT_EN ? 16'd4 : 16'd0)) begin
            $display("FAIL alt_beat_cnt: got %0d expected %0d", beat_cnt, CNT_EN ? 4 : 0);
            n_fail++;
        end
    endtask

    task automatic test_reset_midstream();
        do_reset();
        load(8, 1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            drain_en = 1'b1;
            out_ready = (c < 3);
        end
        #1;
        n_tests++;
        if (out_valid !== 1'b1 || out_data !== 32'h2 || beat_cnt !== (CNT_EN ? 16'd1 : 16'd0)) begin
            $display("FAIL mid_pre_reset: got v=%b d=%h cnt=%0d expected v=1 d=2 cnt=%0d",
                     out_valid, out_data, beat_cnt, CNT_EN ? 1 : 0);
            n_fail++;
        end
        #1 reset = 1'b1;
        #1;
        n_tests++;
        if (read_en !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'h0 || beat_cnt !== 16'h0)
        begin
            $display("FAIL mid_async_reset: got re=%b v=%b d=%h cnt=%0d expected all 0",
                     read_en, out_valid, out_data, beat_cnt);
            n_fail++;
        end
        @(negedge clk);
        wr_ptr = rd_ptr;
        load(1, 32'hAB);
        drain_en = 1'b1;
        out_ready = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        drain_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_tests++;
        if (out_valid !== 1'b0) begin
            $display("FAIL inflight_discard: got valid=%b data=%h expected valid=0",
                     out_valid, out_data);
            n_fail++;
        end
    endtask

    task automatic test_wrap();
        int got = 0;
        bit pend = 1'b0;
        logic [15:0] exp_cnt = 16'h0;
        do_reset();
`ifdef FIFO_DRAIN_BEAT_CNT_EN
        wr_ptr = wr_ptr + 65534;
        drain_en = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 70000 && beat_cnt != 16'hFFFE; i++) @(negedge clk);
        #1;
        n_tests++;
        if (beat_cnt !== 16'hFFFE) begin
            $display("FAIL wrap_preload: got %h expected fffe", beat_cnt); n_fail++;
        end
`endif
        load(3, 32'h100);
        drain_en = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 30 && !(got == 3 && !pend); c++) begin
            @(negedge clk);
            #1;
            if (pend) begin
                n_tests++;
                if (beat_cnt !== exp_cnt) begin
                    $display("FAIL wrap_beat_cnt[%0d]: got %h expected %h", got, beat_cnt,
                             exp_cnt);
                    n_fail++;
                end
                pend = 1'b0;
            end
            if (out_valid && out_ready) begin
                exp_cnt = CNT_EN ? 16'(32'hFFFE + got + 1) : 16'h0;
                pend = 1'b1;
                got++;
            end
        end
        n_tests++;
        if (got !== 3) begin
            $display("FAIL wrap_transfers: got %0d expected 3", got); n_fail++;
        end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_empty();
        test_alternating();
        test_reset_midstream();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
